// File: rtl/btn_debounce.sv
// btn_debounce: push-button conditioner for the doorlock design.
// Synchronizes a raw button pin, rejects contact bounce, and emits a clean
// debounced level plus one-cycle press / release / long-press pulses and a
// "held" level that spans from the long-press pulse until release.
module btn_debounce #(
  parameter int unsigned T_DB   = 1_000_000,   // debounce window, clk cycles
  parameter int unsigned T_LONG = 50_000_000,  // long-press threshold, clk cycles
  parameter bit          INV    = 1'b1,        // 1: button is active-low on din
  parameter int unsigned CNT_W  = 26           // must hold T_LONG-1
) (
  input  logic clk,
  input  logic rst,          // synchronous, active-high
  input  logic din,          // raw asynchronous button pin
  output logic dout,         // debounced level, 1 = pressed
  output logic press,        // pulse on debounced 0->1
  output logic release_evt,  // pulse on debounced 1->0 ("release" is a reserved word)
  output logic long_press,   // pulse after T_LONG pressed cycles
  output logic held          // 1 from long_press until release
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(T_DB - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(T_LONG - 1);

  typedef enum logic [2:0] {
    IDLE,    // released, stable
    DB_ON,   // candidate press, timing the debounce window
    ON,      // pressed, timing the long press
    LONG,    // pressed past the long-press threshold
    DB_OFF   // candidate release, timing the debounce window
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] db_cnt, db_cnt_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  logic             sync1, sync2;
  logic             s;
  logic             dout_nxt, press_nxt, release_nxt, long_nxt, held_nxt;

  // Two-flop synchronizer; both flops reset to the idle pin level so s = 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= INV;
      sync2 <= INV;
    end else begin
      // NOTE: non-blocking assignments let sync2 capture the old sync1;
      // blocking ones here would collapse the two stages into one.
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  assign s = sync2 ^ INV;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      db_cnt   <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      db_cnt   <= db_cnt_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  // Next-state and counter update rules.
  always_comb begin
    // NOTE: every target gets a default before the case, so no path can
    // leave a value unassigned and infer a latch.
    state_nxt    = state;
    db_cnt_nxt   = db_cnt;
    hold_cnt_nxt = hold_cnt;
    unique case (state)
      IDLE: begin
        if (s) begin
          state_nxt  = DB_ON;
          db_cnt_nxt = '0;
        end
      end
      DB_ON: begin
        if (!s) begin
          state_nxt = IDLE;                 // bounce rejected
        end else if (db_cnt == DB_LAST) begin
          state_nxt    = ON;
          hold_cnt_nxt = '0;
        end else begin
          db_cnt_nxt = db_cnt + 1'b1;
        end
      end
      ON: begin
        // A falling input wins over hold expiry in the same cycle.
        if (!s) begin
          state_nxt  = DB_OFF;
          db_cnt_nxt = '0;
        end else if (hold_cnt == LONG_LAST) begin
          state_nxt = LONG;
        end else begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
      LONG: begin
        if (!s) begin
          state_nxt  = DB_OFF;
          db_cnt_nxt = '0;
        end
      end
      DB_OFF: begin
        // hold_cnt stays frozen so a rejected release resumes the count.
        if (s) begin
          state_nxt = held ? LONG : ON;
        end else if (db_cnt == DB_LAST) begin
          state_nxt = IDLE;
        end else begin
          db_cnt_nxt = db_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output values derived from the transition about to be taken.
  always_comb begin
    dout_nxt    = (state_nxt == ON) || (state_nxt == LONG) || (state_nxt == DB_OFF);
    press_nxt   = (state == DB_ON)  && (state_nxt == ON);
    release_nxt = (state == DB_OFF) && (state_nxt == IDLE);
    long_nxt    = (state == ON)     && (state_nxt == LONG);
    held_nxt    = (state_nxt == LONG) || ((state_nxt == DB_OFF) && held);
  end

  // Registered outputs; reset clears everything without a release pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout        <= 1'b0;
      press       <= 1'b0;
      release_evt <= 1'b0;
      long_press  <= 1'b0;
      held        <= 1'b0;
    end else begin
      dout        <= dout_nxt;
      press       <= press_nxt;
      release_evt <= release_nxt;
      long_press  <= long_nxt;
      held        <= held_nxt;
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed scenarios plus a randomized run, all checked
// against a run-length reference model of the debouncer.
module tb_btn_debounce;

  localparam int unsigned T_DB   = 4;
  localparam int unsigned T_LONG = 16;
  localparam bit          INV    = 1'b0;
  localparam int unsigned CNT_W  = 26;

  logic clk = 1'b0;
  logic rst;
  logic din;
  logic dout, press, release_evt, long_press, held;

  btn_debounce #(
    .T_DB  (T_DB),
    .T_LONG(T_LONG),
    .INV   (INV),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .dout       (dout),
    .press      (press),
    .release_evt(release_evt),
    .long_press (long_press),
    .held       (held)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: the debounced level flips once the synchronized input
  // has disagreed with it for T_DB+1 consecutive samples; the long press
  // fires on the T_LONG-th pressed sample taken while not mid-release.
  logic m_d1, m_d2;
  logic m_dout, m_press, m_rel, m_long, m_held;
  int   m_run, m_hold;

  // Observation bookkeeping for directed timing checks.
  int   edge_n = 0;
  int   last_press_edge, last_rel_edge, last_long_edge, pulse_cnt;
  logic held_at_rel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic d, input logic r);
    logic sm;
    if (r) begin
      m_d1 = INV; m_d2 = INV;
      m_dout = 1'b0; m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0; m_held = 1'b0;
      m_run = 0; m_hold = 0;
    end else begin
      sm = m_d2 ^ INV;
      m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
      if (sm != m_dout) begin
        m_run++;
        if (m_run == int'(T_DB) + 1) begin
          m_run = 0;
          if (sm) begin
            m_dout = 1'b1; m_press = 1'b1; m_hold = 0;
          end else begin
            m_dout = 1'b0; m_rel = 1'b1; m_held = 1'b0;
          end
        end
      end else begin
        if (m_dout && !m_held && m_run == 0) begin
          m_hold++;
          if (m_hold == int'(T_LONG)) begin
            m_long = 1'b1; m_held = 1'b1;
          end
        end
        m_run = 0;
      end
      m_d2 = m_d1;
      m_d1 = d;
    end
  endtask

  // One clock: drive inputs, advance the model, compare all outputs.
  task automatic step(input logic d, input logic r);
    din = d;
    rst = r;
    @(posedge clk);
    edge_n++;
    model_edge(d, r);
    #1;
    check($sformatf("dout@%0d", edge_n),       dout,        m_dout);
    check($sformatf("press@%0d", edge_n),      press,       m_press);
    check($sformatf("release@%0d", edge_n),    release_evt, m_rel);
    check($sformatf("long_press@%0d", edge_n), long_press,  m_long);
    check($sformatf("held@%0d", edge_n),       held,        m_held);
    if (press === 1'b1)      last_press_edge = edge_n;
    if (long_press === 1'b1) last_long_edge  = edge_n;
    if (release_evt === 1'b1) begin
      last_rel_edge = edge_n;
      held_at_rel   = held;
    end
    if (press === 1'b1 || release_evt === 1'b1 || long_press === 1'b1) pulse_cnt++;
  endtask

  task automatic clear_marks();
    last_press_edge = -1;
    last_rel_edge   = -1;
    last_long_edge  = -1;
    pulse_cnt       = 0;
    held_at_rel     = 1'bx;
  endtask

  task automatic repeat_step(input logic d, input int n);
    for (int i = 0; i < n; i++) step(d, 1'b0);
  endtask

  initial begin
    int base;
    int bounce [5];
    logic lvl;
    int   len;

    din = 1'b1;
    rst = 1'b1;
    clear_marks();

    // 1. Reset held 3 cycles with din=1, then release: fresh press at edge 6.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    check("reset_dout", dout, 0);
    check("reset_held", held, 0);
    base = edge_n + 1;
    repeat_step(1'b1, 8);
    check("rst_press_edge", last_press_edge, base + 6);
    repeat_step(1'b0, 10);

    // 2. Clean press for 10 cycles, then release 6 edges after the drop.
    clear_marks();
    repeat_step(1'b0, 3);
    base = edge_n + 1;
    repeat_step(1'b1, 10);
    check("clean_press_edge", last_press_edge, base + 6);
    check("clean_no_long", last_long_edge, -1);
    base = edge_n + 1;
    repeat_step(1'b0, 10);
    check("clean_release_edge", last_rel_edge, base + 6);

    // 3. Bounce 1,0,1,1,0 then settle low: no level change, no pulses.
    clear_marks();
    bounce = '{1, 0, 1, 1, 0};
    foreach (bounce[i]) step(bounce[i][0], 1'b0);
    repeat_step(1'b0, 10);
    check("bounce_pulses", pulse_cnt, 0);
    check("bounce_dout", dout, 0);

    // 4. Long press: press at 6, long_press at 6+16; held clears with release.
    clear_marks();
    base = edge_n + 1;
    repeat_step(1'b1, 30);
    check("long_press_edge", last_press_edge, base + 6);
    check("long_long_edge", last_long_edge, base + 6 + int'(T_LONG));
    check("long_held", held, 1);
    repeat_step(1'b0, 10);
    check("long_held_at_release", held_at_rel, 0);
    check("long_release_seen", (last_rel_edge > 0), 1);

    // 5. Release bounce of 2 cycles while in ON: no release, long_press
    //    pushed back by the three edges that see s=0 or return from DB_OFF.
    clear_marks();
    base = edge_n + 1;
    repeat_step(1'b1, 9);
    repeat_step(1'b0, 2);
    repeat_step(1'b1, 20);
    check("rbounce_no_release", last_rel_edge, -1);
    check("rbounce_dout", dout, 1);
    check("rbounce_long_edge", last_long_edge, base + 6 + int'(T_LONG) + 3);
    repeat_step(1'b0, 10);

    // 6. Reset while in LONG: outputs clear, no release, fresh press after.
    clear_marks();
    repeat_step(1'b1, 30);
    check("midrst_in_long", held, 1);
    step(1'b1, 1'b1);
    check("midrst_dout", dout, 0);
    check("midrst_held", held, 0);
    base = edge_n + 1;
    repeat_step(1'b1, 8);
    check("midrst_no_release", last_rel_edge, -1);
    check("midrst_press_edge", last_press_edge, base + 6);
    repeat_step(1'b0, 10);

    // Randomized runs of bouncy and steady levels, with occasional resets.
    for (int seg = 0; seg < 150; seg++) begin
      lvl = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 30))
                                        : int'($urandom_range(1, 7));
      for (int i = 0; i < len; i++) step(lvl, 1'b0);
      if ($urandom_range(0, 24) == 0) step(lvl, 1'b1);
    end
    repeat_step(1'b0, 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
